// File: rtl/progmem_pkg.sv
// Shared types and constants for the program memory: controller states and
// the instruction word returned on any fetch that cannot be served.
package progmem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2
    } state_e;

    localparam logic [31:0] MIPS_NOP = 32'h0000_0000;

endpackage

// File: rtl/progmem_ram.sv
// Simple dual-port storage: one synchronous write port, one synchronous read
// port with a read enable so the output holds between reads. No reset.
module progmem_ram #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] rdata_reg;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata_reg <= mem[raddr];
        end
    end

    assign rdata = rdata_reg;

endmodule

// File: rtl/progmem.sv
// Instruction memory with a streaming program loader and a one-cycle fetch
// port; fetches that cannot be served return NOP_WORD with fetch_err set.
module progmem
    import progmem_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 8,
    parameter int                    DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] NOP_WORD   = DATA_WIDTH'(MIPS_NOP)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load_start,
    input  logic                  load_valid,
    input  logic [DATA_WIDTH-1:0] load_data,
    input  logic                  load_last,
    output logic                  load_ready,
    output logic                  load_done,
    output logic [ADDR_WIDTH:0]   load_count,
    input  logic                  fetch_req,
    input  logic [31:0]           fetch_addr,
    output logic                  fetch_valid,
    output logic [DATA_WIDTH-1:0] instr,
    output logic                  fetch_err
);

    state_e                state_reg, state_next;
    logic [ADDR_WIDTH-1:0] wr_ptr_reg, wr_ptr_next;
    logic [ADDR_WIDTH:0]   count_reg, count_next;
    logic                  done_reg, done_next;
    logic                  valid_reg, err_reg, nop_sel_reg;

    logic                  beat;
    logic [ADDR_WIDTH-1:0] fetch_idx;
    logic                  upper_bad;
    logic                  fetch_bad;
    logic                  rd_en;
    logic [DATA_WIDTH-1:0] ram_rdata;

    assign beat = (state_reg == ST_LOAD) && load_valid;

    always_comb begin
        state_next  = state_reg;
        wr_ptr_next = wr_ptr_reg;
        count_next  = count_reg;
        done_next   = 1'b0;
        unique case (state_reg)
            ST_IDLE, ST_RUN: begin
                if (load_start) begin
                    state_next  = ST_LOAD;
                    wr_ptr_next = '0;
                    count_next  = '0;
                end
            end
            ST_LOAD: begin
                if (load_valid) begin
                    wr_ptr_next = wr_ptr_reg + 1'b1;
                    count_next  = count_reg + 1'b1;
                    // An all-ones pointer means this beat fills the last word.
                    if (load_last || (&wr_ptr_reg)) begin
                        state_next = ST_RUN;
                        done_next  = 1'b1;
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    assign fetch_idx = fetch_addr[ADDR_WIDTH+1:2];
    assign upper_bad = (fetch_addr >> (ADDR_WIDTH + 2)) != 32'd0;
    assign fetch_bad = (state_reg != ST_RUN) || load_start
                     || (fetch_addr[1:0] != 2'b00) || upper_bad
                     || ({1'b0, fetch_idx} >= count_reg);
    assign rd_en     = fetch_req && !fetch_bad;

    // nop_sel_reg only moves on a fetch, so instr holds between requests.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg  <= '0;
            count_reg   <= '0;
            done_reg    <= 1'b0;
            valid_reg   <= 1'b0;
            err_reg     <= 1'b0;
            nop_sel_reg <= 1'b1;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            count_reg  <= count_next;
            done_reg   <= done_next;
            valid_reg  <= fetch_req;
            err_reg    <= fetch_req && fetch_bad;
            if (fetch_req) begin
                nop_sel_reg <= fetch_bad;
            end
        end
    end

    progmem_ram #(
        .ADDR_WIDTH(ADDR_WIDTH),
        .DATA_WIDTH(DATA_WIDTH)
    ) u_ram (
        .clk  (clk),
        .we   (beat),
        .waddr(wr_ptr_reg),
        .wdata(load_data),
        .re   (rd_en),
        .raddr(fetch_idx),
        .rdata(ram_rdata)
    );

    assign load_ready  = (state_reg == ST_LOAD);
    assign load_done   = done_reg;
    assign load_count  = count_reg;
    assign fetch_valid = valid_reg;
    assign fetch_err   = err_reg;
    assign instr       = nop_sel_reg ? NOP_WORD : ram_rdata;

endmodule

// File: tb/tb_progmem.sv
// Bench for progmem: directed load/fetch scenarios plus a randomized phase,
// every cycle compared against a word-level model of the loader and fetch port.
module tb_progmem;

    localparam int          AW    = 8;
    localparam int          DW    = 32;
    localparam int          DEPTH = 256;
    localparam logic [31:0] NOP   = 32'h0000_0000;

    logic          clk        = 1'b0;
    logic          rst_n      = 1'b0;
    logic          load_start = 1'b0;
    logic          load_valid = 1'b0;
    logic [DW-1:0] load_data  = '0;
    logic          load_last  = 1'b0;
    logic          fetch_req  = 1'b0;
    logic [31:0]   fetch_addr = '0;
    logic          load_ready, load_done, fetch_valid, fetch_err;
    logic [AW:0]   load_count;
    logic [DW-1:0] instr;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    progmem #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .NOP_WORD  (NOP)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_start (load_start),
        .load_valid (load_valid),
        .load_data  (load_data),
        .load_last  (load_last),
        .load_ready (load_ready),
        .load_done  (load_done),
        .load_count (load_count),
        .fetch_req  (fetch_req),
        .fetch_addr (fetch_addr),
        .fetch_valid(fetch_valid),
        .instr      (instr),
        .fetch_err  (fetch_err)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // Word-level model: program image, number of loaded words, mode.
    typedef enum int {M_IDLE, M_LOAD, M_RUN} mode_t;
    mode_t       m_mode    = M_IDLE;
    int          m_count   = 0;
    logic [31:0] m_mem [DEPTH];
    logic        e_valid   = 1'b0;
    logic        e_err     = 1'b0;
    logic        e_done    = 1'b0;
    logic [31:0] e_instr   = NOP;
    logic [31:0] e_addr    = '0;
    longint      m_word;
    bit          m_bad;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_mode  = M_IDLE;
            m_count = 0;
            e_valid = 1'b0;
            e_err   = 1'b0;
            e_done  = 1'b0;
            e_instr = NOP;
        end else begin
            if (fetch_req) begin
                m_word  = longint'(fetch_addr) / 4;
                m_bad   = (m_mode != M_RUN) || load_start
                        || (fetch_addr % 4 != 0) || (m_word >= m_count);
                e_valid = 1'b1;
                e_err   = m_bad;
                e_addr  = fetch_addr;
                if (m_bad) e_instr = NOP;
                else       e_instr = m_mem[int'(m_word)];
            end else begin
                e_valid = 1'b0;
                e_err   = 1'b0;
            end
            e_done = 1'b0;
            if (m_mode == M_LOAD) begin
                if (load_valid) begin
                    m_mem[m_count] = load_data;
                    m_count++;
                    if (load_last || m_count == DEPTH) begin
                        m_mode = M_RUN;
                        e_done = 1'b1;
                    end
                end
            end else if (load_start) begin
                m_mode  = M_LOAD;
                m_count = 0;
            end
        end
    end

    always @(negedge clk) begin
        chk("load_ready",  load_ready,  m_mode == M_LOAD);
        chk("load_done",   load_done,   e_done);
        chk("load_count",  load_count,  m_count);
        chk("fetch_valid", fetch_valid, e_valid);
        chk("fetch_err",   fetch_err,   e_err);
        chk("instr",       instr,       e_instr);
        if (e_valid)
            $display("fetch addr=%08h instr=%08h err=%0b", e_addr, instr, fetch_err);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        load_start = 1'b0;
        load_valid = 1'b0;
        load_last  = 1'b0;
        fetch_req  = 1'b0;
    endtask

    task automatic fetch(input logic [31:0] a);
        quiet();
        fetch_req  = 1'b1;
        fetch_addr = a;
        step();
        fetch_req  = 1'b0;
    endtask

    logic [31:0] prog [4] = '{32'h20080005, 32'h20090007, 32'h01095020, 32'hAC0A0000};
    logic [31:0] full [DEPTH];

    task automatic load_prog();
        quiet();
        load_start = 1'b1;
        step();
        for (int i = 0; i < 4; i++) begin
            quiet();
            load_valid = 1'b1;
            load_data  = prog[i];
            load_last  = (i == 3);
            step();
        end
        quiet();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        repeat (3) step();
        rst_n = 1'b1;
        step();
        chk("reset_count", load_count, 0);
        chk("reset_ready", load_ready, 0);
        chk("reset_instr", instr, NOP);

        // Fetch in IDLE
        fetch(32'h0);
        chk("idle_fetch_valid", fetch_valid, 1);
        chk("idle_fetch_err", fetch_err, 1);

        // Four-word program; fetch during the first load beat
        quiet();
        load_start = 1'b1;
        step();
        for (int i = 0; i < 4; i++) begin
            quiet();
            load_valid = 1'b1;
            load_data  = prog[i];
            load_last  = (i == 3);
            fetch_req  = (i == 0);
            fetch_addr = 32'h0;
            step();
            if (i == 0) begin
                chk("load_fetch_err", fetch_err, 1);
                chk("load_fetch_instr", instr, NOP);
            end
        end
        quiet();
        chk("prog_done", load_done, 1);
        chk("prog_count", load_count, 4);
        chk("prog_ready", load_ready, 0);
        step();
        chk("prog_done_pulse", load_done, 0);

        for (int i = 0; i < 4; i++) begin
            fetch_req  = 1'b1;
            fetch_addr = 32'(i * 4);
            step();
            chk("b2b_instr", instr, prog[i]);
            chk("b2b_err", fetch_err, 0);
            chk("b2b_valid", fetch_valid, 1);
        end
        fetch(32'h10);
        chk("range_err", fetch_err, 1);
        chk("range_instr", instr, 32'h0);
        fetch(32'h6);
        chk("misalign_err", fetch_err, 1);
        fetch(32'h8);
        step();
        chk("hold_valid", fetch_valid, 0);
        chk("hold_instr", instr, 32'h01095020);

        // Full-depth load without load_last
        quiet();
        load_start = 1'b1;
        step();
        for (int i = 0; i < DEPTH; i++) begin
            quiet();
            load_valid = 1'b1;
            full[i]    = $urandom;
            load_data  = full[i];
            step();
        end
        chk("full_count", load_count, 256);
        chk("full_ready", load_ready, 0);
        chk("full_done", load_done, 1);
        load_valid = 1'b1;
        load_data  = 32'hDEADBEEF;
        step();
        chk("overflow_count", load_count, 256);
        fetch(32'h3FC);
        chk("full_last_word", instr, full[255]);
        fetch(32'h0);
        chk("full_first_word", instr, full[0]);
        fetch(32'h400);
        chk("upper_bits_err", fetch_err, 1);

        // Reset in the middle of a load
        quiet();
        load_start = 1'b1;
        step();
        for (int i = 0; i < 2; i++) begin
            quiet();
            load_valid = 1'b1;
            load_data  = prog[i];
            step();
        end
        quiet();
        rst_n = 1'b0;
        #1;
        chk("async_rst_count", load_count, 0);
        chk("async_rst_ready", load_ready, 0);
        chk("async_rst_instr", instr, NOP);
        step();
        rst_n = 1'b1;
        step();
        fetch(32'h0);
        chk("post_rst_fetch_err", fetch_err, 1);

        // Reload from RUN with a coincident fetch
        load_prog();
        quiet();
        load_start = 1'b1;
        fetch_req  = 1'b1;
        fetch_addr = 32'h0;
        step();
        chk("reload_fetch_err", fetch_err, 1);
        chk("reload_count", load_count, 0);
        chk("reload_ready", load_ready, 1);
        quiet();
        load_valid = 1'b1;
        load_last  = 1'b1;
        load_data  = 32'h12345678;
        step();
        fetch(32'h0);
        chk("reload_word0", instr, 32'h12345678);

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            load_start = ($urandom_range(0, 39) == 0);
            load_valid = ($urandom_range(0, 2) != 0);
            load_data  = $urandom;
            load_last  = ($urandom_range(0, 11) == 0);
            fetch_req  = $urandom_range(0, 1) == 1;
            case ($urandom_range(0, 9))
                0:       fetch_addr = 32'($urandom_range(0, 255));
                1:       fetch_addr = $urandom;
                default: fetch_addr = 32'($urandom_range(0, 79)) << 2;
            endcase
            step();
        end
        quiet();
        step();
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
